// File: rtl/ndma_pkg.sv
// Shared NanoDMA definitions: command-state encoding and the default
// outstanding-read depth used by the read manager.
package ndma_pkg;

  localparam int unsigned MaxOutDefault = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    PEND  = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/ndma_obi_bus.sv
// Shared NanoDMA OBI bus bundle (32-bit address/data) with manager and
// subordinate views.
interface OBI_BUS;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport Manager (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport Subordinate (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/ndma_fifo.sv
// Small synchronous FIFO with registered storage; head reads as zero when
// empty, and a pop while empty is ignored.
module ndma_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CntW'(push_i) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ndma_read_mgr.sv
// NanoDMA read manager: single-entry command stage issuing OBI reads, with a
// credit counter bounding in-flight reads to the depth of the response FIFO.
module ndma_read_mgr
  import ndma_pkg::*;
#(
  parameter int unsigned MaxOut = MaxOutDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        rready_i,
  output logic        busy_o,
  OBI_BUS.Manager     read_mgr
);

  localparam int unsigned CntW = $clog2(MaxOut + 1);

  cmd_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [32:0]      fifo_head;

  assign ready_o = (state_q == EMPTY) && (cnt_q < CntW'(MaxOut));
  assign accept  = req_i && ready_o;
  assign pop     = rvalid_o && rready_i;
  assign busy_o  = (cnt_q != '0);

  assign read_mgr.req   = (state_q == PEND);
  assign read_mgr.addr  = (state_q == PEND) ? addr_q : '0;
  assign read_mgr.we    = 1'b0;
  assign read_mgr.be    = '1;
  assign read_mgr.wdata = '0;

  // A credit is taken on command accept and returned on pop, so the FIFO
  // can never hold more responses than it has entries.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = PEND;
          addr_d  = addr_i;
        end
      end
      PEND: begin
        if (read_mgr.gnt) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!accept && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  ndma_fifo #(
    .Width (33),
    .Depth (MaxOut)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (read_mgr.rvalid),
    .data_i  ({read_mgr.err, read_mgr.rdata}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rvalid_o = !fifo_empty;
  assign rdata_o  = fifo_head[31:0];
  assign err_o    = fifo_head[32];

  rsp_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) read_mgr.rvalid |-> !fifo_full
  );

endmodule

// File: tb/tb_ndma_read_mgr.sv
// Directed bench for ndma_read_mgr (MaxOut=2) with the OBI subordinate
// driven by hand-sequenced gnt/rvalid stimulus.
module tb_ndma_read_mgr;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] addr_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rready_i;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_i = ~clk_i;

  OBI_BUS bus ();

  ndma_read_mgr #(
    .MaxOut (2)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .ready_o  (ready_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .rready_i (rready_i),
    .busy_o   (busy_o),
    .read_mgr (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.err    = e;
    step();
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.err    = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ready"},  32'(ready_o),  32'd1);
    check({pfx, "_rvalid"}, 32'(rvalid_o), 32'd0);
    check({pfx, "_rdata"},  rdata_o,       32'd0);
    check({pfx, "_err"},    32'(err_o),    32'd0);
    check({pfx, "_busy"},   32'(busy_o),   32'd0);
    check({pfx, "_obireq"}, 32'(bus.req),  32'd0);
    check({pfx, "_obiaddr"}, bus.addr,     32'd0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    req_i      = 1'b0;
    addr_i     = '0;
    rready_i   = 1'b0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.err    = 1'b0;

    #2;
    check_reset("rst");
    check("rst_we",    32'(bus.we), 32'd0);
    check("rst_be",    32'(bus.be), 32'hF);
    check("rst_wdata", bus.wdata,   32'd0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // single read, gnt in the same cycle as the OBI request
    bus.gnt = 1'b1;
    req_i   = 1'b1;
    addr_i  = 32'h0000_1000;
    check("t1_ready", 32'(ready_o), 32'd1);
    step();
    req_i  = 1'b0;
    addr_i = '0;
    check("t1_obireq",  32'(bus.req), 32'd1);
    check("t1_obiaddr", bus.addr,     32'h0000_1000);
    check("t1_ready_pend", 32'(ready_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    step();
    check("t1_obireq_done",  32'(bus.req), 32'd0);
    check("t1_obiaddr_idle", bus.addr,     32'd0);
    step();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    bus.err    = 1'b0;
    check("t1_no_bypass", 32'(rvalid_o), 32'd0);
    step();
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    check("t1_rvalid", 32'(rvalid_o), 32'd1);
    check("t1_rdata",  rdata_o,       32'hDEAD_BEEF);
    check("t1_err",    32'(err_o),    32'd0);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("t1_rvalid_pop", 32'(rvalid_o), 32'd0);
    check("t1_rdata_pop",  rdata_o,       32'd0);
    check("t1_busy_pop",   32'(busy_o),   32'd0);

    // gnt stall: request and address must hold while gnt is low
    bus.gnt = 1'b0;
    req_i   = 1'b1;
    addr_i  = 32'h0000_1000;
    step();
    req_i  = 1'b0;
    addr_i = '0;
    for (int i = 0; i < 5; i++) begin
      check("stall_obireq",  32'(bus.req),  32'd1);
      check("stall_obiaddr", bus.addr,      32'h0000_1000);
      check("stall_ready",   32'(ready_o),  32'd0);
      step();
    end
    bus.gnt = 1'b1;
    check("stall_obireq_gnt", 32'(bus.req), 32'd1);
    step();
    check("stall_obireq_done", 32'(bus.req), 32'd0);
    respond(32'h1234_5678, 1'b0);
    check("stall_rdata", rdata_o, 32'h1234_5678);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("stall_busy_end", 32'(busy_o), 32'd0);

    // credit limit with rready_i low: third command waits for the first pop
    req_i  = 1'b1;
    addr_i = 32'h10;
    step();
    addr_i = 32'h14;
    check("cr_obiaddr1", bus.addr, 32'h10);
    step();
    check("cr_ready_cnt1", 32'(ready_o), 32'd1);
    step();
    addr_i = 32'h18;
    check("cr_obiaddr2", bus.addr, 32'h14);
    step();
    check("cr_ready_cnt2", 32'(ready_o), 32'd0);
    respond(32'hA000_0010, 1'b0);
    respond(32'hA000_0014, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("cr_ready_wait", 32'(ready_o), 32'd0);
      check("cr_obireq_idle", 32'(bus.req), 32'd0);
      step();
    end
    check("cr_head1", rdata_o, 32'hA000_0010);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("cr_ready_after_pop", 32'(ready_o), 32'd1);
    check("cr_head2", rdata_o, 32'hA000_0014);
    step();
    req_i  = 1'b0;
    addr_i = '0;
    check("cr_obiaddr3", bus.addr, 32'h18);
    step();
    respond(32'hA000_0018, 1'b0);
    check("cr_head2_hold", rdata_o, 32'hA000_0014);
    rready_i = 1'b1;
    step();
    check("cr_head3", rdata_o, 32'hA000_0018);
    step();
    rready_i = 1'b0;
    check("cr_rvalid_end", 32'(rvalid_o), 32'd0);
    check("cr_busy_end",   32'(busy_o),   32'd0);

    // error response passes through and still returns its credit
    req_i  = 1'b1;
    addr_i = 32'h20;
    step();
    req_i = 1'b0;
    step();
    respond(32'h0, 1'b1);
    check("err_rvalid", 32'(rvalid_o), 32'd1);
    check("err_flag",   32'(err_o),    32'd1);
    check("err_rdata",  rdata_o,       32'd0);
    check("err_busy",   32'(busy_o),   32'd1);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("err_busy_pop", 32'(busy_o), 32'd0);
    check("err_flag_pop", 32'(err_o),  32'd0);

    // same-cycle accept and pop at cnt=1 leaves the count at 1
    req_i  = 1'b1;
    addr_i = 32'h30;
    step();
    req_i = 1'b0;
    step();
    respond(32'hC000_0030, 1'b0);
    check("sim_ready", 32'(ready_o), 32'd1);
    req_i    = 1'b1;
    addr_i   = 32'h34;
    rready_i = 1'b1;
    step();
    req_i    = 1'b0;
    rready_i = 1'b0;
    check("sim_busy",     32'(busy_o),   32'd1);
    check("sim_rvalid",   32'(rvalid_o), 32'd0);
    check("sim_obiaddr",  bus.addr,      32'h34);
    step();
    check("sim_ready_next", 32'(ready_o), 32'd1);
    respond(32'hC000_0034, 1'b0);
    check("sim_rdata", rdata_o, 32'hC000_0034);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    check("sim_busy_end", 32'(busy_o), 32'd0);

    // asynchronous reset with cnt=2 and a read still outstanding
    req_i  = 1'b1;
    addr_i = 32'h40;
    step();
    req_i = 1'b0;
    step();
    respond(32'hE000_0040, 1'b0);
    bus.gnt = 1'b0;
    req_i   = 1'b1;
    addr_i  = 32'h44;
    step();
    req_i  = 1'b0;
    addr_i = '0;
    check("rs_busy_pre",   32'(busy_o),   32'd1);
    check("rs_obireq_pre", 32'(bus.req),  32'd1);
    check("rs_rvalid_pre", 32'(rvalid_o), 32'd1);
    check("rs_ready_pre",  32'(ready_o),  32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("rs_mid");
    step();
    rst_ni  = 1'b1;
    bus.gnt = 1'b1;
    step();
    check("rs_ready_after",  32'(ready_o),  32'd1);
    check("rs_busy_after",   32'(busy_o),   32'd0);
    check("rs_rvalid_after", 32'(rvalid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
